seg_scan: RTL
=============

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles each digit is held active; legal range 2 to 2^20.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port s_in  input  32  four-digit active-low segment pattern; s_in[31:24] is the leftmost digit, s_in[7:0] the rightmost; each byte is {a,b,c,d,e,f,g,dp} with bit 7 = a.
REQ-005 SHALL have port load  input  1  single-cycle request to capture s_in.
REQ-006 SHALL have port en  input  1  display enable; low blanks the display and freezes scanning.
REQ-007 SHALL have port an  output  4  active-low digit anodes; an[3] is the leftmost digit.
REQ-008 SHALL have port seg  output  8  active-low cathodes {a,b,c,d,e,f,g,dp}, with seg[7] = a.
REQ-009 SHALL have port frame_tick  output  1  one-cycle pulse marking completion of a full four-digit scan.

Function
REQ-010 SHALL hold a 32-bit pattern register pat; digit k displays pat[8k+7:8k].
REQ-011 SHALL run refresh counter cnt 0..REFRESH_DIV-1 while en=1, wrapping to 0 and advancing digit index idx on the wrap cycle.
REQ-012 SHALL advance idx 0->1->2->3->0 and hold cnt and idx while en=0.
REQ-013 SHALL register an and seg each cycle: an = one-cold at idx (an[idx]=0), seg = pat byte idx; outputs lag idx/pat by exactly one cycle.
REQ-014 SHALL drive an=4'b1111 and seg=8'hFF on the cycle after en is sampled low; resumption on en=1 continues from the frozen cnt/idx.
REQ-015 SHALL assert frame_tick for exactly one cycle, registered, on the cycle after cnt wraps while idx=3 and en=1.
REQ-016 SHALL, without SEG_SNAPSHOT_EN, load pat <= s_in on the edge where load=1, with the new byte visible on seg on the following cycle if its digit is active.
REQ-017 SHALL ignore s_in whenever load=0; repeated load pulses each overwrite pat, the last one winning.

Reset
REQ-018 SHALL, on rst asserted, immediately force cnt=0, idx=0, pat=32'hFFFF_FFFF, an=4'b1111, seg=8'hFF, frame_tick=0 and pending flag=0, independent of clk.
REQ-019 SHALL, after rst deasserts mid-scan, restart from digit 0 with a full REFRESH_DIV dwell, the first non-blank an appearing one cycle after the first clk edge with en=1.

Configuration
REQ-020 SHALL compile tear-free update logic only when macro SEG_SNAPSHOT_EN is defined.
REQ-021 SHALL, with SEG_SNAPSHOT_EN, capture s_in into a pending register on load and set pending=1, copying pending into pat and clearing pending on the frame-boundary cycle (cnt wrap at idx=3, en=1).
REQ-022 SHALL, with SEG_SNAPSHOT_EN, load s_in directly into pat and leave pending=0 when load coincides with the frame boundary; a later load before the boundary overwrites pending.
REQ-023 SHALL, without SEG_SNAPSHOT_EN, omit the pending register and flag entirely, behaving per REQ-016.

Verification (REFRESH_DIV=4)
REQ-024 SHALL cover: rst pulse mid-scan -> an=4'b1111, seg=8'hFF asynchronously; after release with en=1, an=4'b1110 for 4 cycles, then 4'b1101, 4'b1011, 4'b0111.
REQ-025 SHALL cover: load with s_in=32'hFF11_D585 (AND), en=1 -> seg reads 8'h85, 8'hD5, 8'h11, 8'hFF as an steps 4'b1110..4'b0111.
REQ-026 SHALL cover: 3 full frames -> frame_tick high for exactly 3 single cycles, spaced 16 cycles apart.
REQ-027 SHALL cover: en=0 for 10 cycles during digit 2 -> an=4'b1111, seg=8'hFF; after en=1, digit 2 finishes its remaining dwell, so no digit receives more than 4 active cycles per visit.
REQ-028 SHALL cover, with SEG_SNAPSHOT_EN: load 32'h0000_0000 during digit 1 -> seg unchanged until frame_tick, then 8'h00 on every digit; a load coincident with the boundary shows the new value on the next cycle.
REQ-029 SHALL cover, without SEG_SNAPSHOT_EN, the same load as REQ-028 -> seg=8'h00 on the cycle after load.

Source files
------------

// File: rtl/seg_scan.sv
// Time-multiplexed four-digit seven-segment scanner with registered, active-low anode/cathode drive.
// Define SEG_SNAPSHOT_EN to defer pattern loads to the next frame boundary, so a frame never shows a mix of old and new patterns.
module seg_scan #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] s_in,
   input  logic        load,
   input  logic        en,
   output logic [3:0]  an,
   output logic [7:0]  seg,
   output logic        frame_tick
);

   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [31:0]   pat;
   logic          wrap;
   logic          boundary;

   assign wrap     = (cnt == CNT_LAST);
   assign boundary = en && wrap && (idx == 2'd3);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= 2'd0;
      end else if (en) begin
         if (wrap) begin
            cnt <= '0;
            idx <= idx + 2'd1;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // Outputs are registered so they lag idx/pat by one cycle and never glitch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an         <= 4'b1111;
         seg        <= 8'hFF;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= boundary;
         if (en) begin
            an  <= ~(4'b0001 << idx);
            seg <= pat[{idx, 3'b000} +: 8];
         end else begin
            an  <= 4'b1111;
            seg <= 8'hFF;
         end
      end
   end

`ifdef SEG_SNAPSHOT_EN
   logic [31:0] pend;
   logic        pending;

   // A load on the boundary itself bypasses the pending stage; otherwise loads wait for the boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat     <= 32'hFFFF_FFFF;
         pend    <= 32'hFFFF_FFFF;
         pending <= 1'b0;
      end else if (boundary) begin
         pending <= 1'b0;
         if (load) begin
            pat <= s_in;
         end else if (pending) begin
            pat <= pend;
         end
      end else if (load) begin
         pend    <= s_in;
         pending <= 1'b1;
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat <= 32'hFFFF_FFFF;
      end else if (load) begin
         pat <= s_in;
      end
   end
`endif

endmodule
